dm_ctrl: RTL and testbench
==========================

Name: dm_ctrl

Overview:
Parametrised data-memory controller for the pipelined MIPS core's M stage, replacing the fixed word-only data memory. Adds byte/halfword/word stores with byte-lane merge, and sign/zero-extended loads. Uses a valid/ready request channel with configurable read latency and a hardware clear sequencer after reset. Keeps the write trace log used by the grading flow.

Parameters:
ADDR_W, 10, word-index width; storage depth = 2^ADDR_W words of 32 bits
LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..4
TRACE, 1, when 1 each committed write issues the $display trace line

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  load zero-extends when 1 (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
req_pc  in  32  PC of the issuing instruction, used only for the trace
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid: misaligned, out-of-range, or size 3
init_done  out  1  clear sequence finished

Behaviour:
- States: CLEAR, IDLE, BUSY.
- Async reset asserted:
  - state <= CLEAR, clear index <= 0.
  - req_ready, rsp_valid, rsp_err, init_done <= 0; rsp_rdata <= 0.
  - Any in-flight request is discarded and no response is issued for it.
- CLEAR:
  - Writes 0 to one word per cycle, index 0 .. 2^ADDR_W-1. This takes 2^ADDR_W cycles after reset deasserts.
  - On the last word: init_done <= 1, go to IDLE. init_done then stays 1 until the next reset.
- IDLE: req_ready = 1. Acceptance is req_valid && req_ready in cycle T.
- Request processing at the edge closing cycle T:
  - Range check: addr[31:ADDR_W+2] must be 0.
  - Alignment check: half needs addr[0] = 0; word needs addr[1:0] = 0.
  - Legal store: lane merge into word addr[ADDR_W+1:2].
    - byte: lane = addr[1:0].
    - half: lanes {addr[1],0} and {addr[1],1}.
    - word: all four lanes.
    - Untouched lanes keep their old value.
  - Legal load: extract the lane(s), then sign-extend or zero-extend per req_unsigned. req_unsigned is ignored for word loads.
  - Error: no storage change; response has rsp_err = 1 and rsp_rdata = 0.
- Response timing:
  - rsp_valid = 1 in cycle T+LATENCY only. rsp_rdata and rsp_err are valid only in that cycle and hold their value otherwise.
  - State is BUSY during cycles T+1 .. T+LATENCY-1, where req_ready = 0. For LATENCY = 1 there is no BUSY cycle.
  - In cycle T+LATENCY the controller is back in IDLE with req_ready = 1. A new acceptance in the response cycle is legal, giving throughput of 1 request per LATENCY cycles.
- One request outstanding at most. Storage is updated at acceptance, so a load accepted after a store's acceptance always sees that store.
- Trace (TRACE = 1, legal store only), at the commit edge:
  - "%d@%h: *%h <= %h" with $time, req_pc, word-aligned byte address, merged 32-bit word.
  - Errored stores print nothing.
- req_valid while not ready (CLEAR or BUSY): ignored. The requester must hold it until accepted.
- Reset asserted mid-BUSY: the response is suppressed and CLEAR restarts from index 0. Storage contents are therefore always zero after a completed clear.

Decomposition:
- Shared package dm_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - state encoding CLEAR/IDLE/BUSY.
  - DM_LAT_MAX = 4.
- One combinational sub-module, dm_byte_lane:
  - Inputs: old word, wdata, size, addr[1:0], unsigned flag.
  - Outputs: merged word, extended load value, misalign flag.
  - Instantiated once.
- dm_ctrl holds storage, FSM and the latency shift register.

Test Plan:
- Reset low 3 cycles, then high (ADDR_W=4) -> req_ready=0 for 16 cycles, then init_done=1, req_ready=1; lw of every word returns 0.
- sw 0x0000_0010 <= 0xDEADBEEF, pc 0x3000, then lw 0x10 -> trace "@00003000: *00000010 <= deadbeef"; with LATENCY=1, rsp_valid one cycle after each accept; rdata 0xDEADBEEF, err 0.
- sb 0x13 <= 0x80 over 0xDEADBEEF -> word becomes 0x80ADBEEF; lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80AD.
- sh 0x11, lw 0x12, size=3 each -> rsp_err=1, rdata=0, no trace, storage unchanged. lw at 0x0000_1000 with ADDR_W=10 -> rsp_err=1.
- LATENCY=3, back-to-back requests held valid -> accepts at cycles T, T+3, T+6; rsp_valid at T+3, T+6, T+9; req_ready low in BUSY cycles.
- Reset asserted in cycle T+1 of a LATENCY=3 load -> no rsp_valid; init_done drops to 0 and returns after a full clear; earlier stores read back 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the M-stage data-memory controller.
package dm_pkg;

  localparam int unsigned DM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } dm_size_e;

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StIdle  = 2'd1,
    StBusy  = 2'd2
  } dm_state_e;

  // Byte accesses are always aligned; the reserved size is reported separately.
  function automatic logic dm_misaligned(logic [1:0] size, logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = lsb[0];
    end else if (size == SZ_WORD) begin
      mis = |lsb;
    end
    return mis;
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response channel between the M stage and the data-memory controller.
interface dm_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/dm_byte_lane.sv
// Byte-lane store merge and sign/zero-extending load extraction for one 32-bit word.
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lsb_i,
  input  logic        unsigned_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_sh    = {lsb_i, 3'b000};
    half_sh    = {lsb_i[1], 4'b0000};
    byte_v     = 8'(old_i >> byte_sh);
    half_v     = 16'(old_i >> half_sh);
    merged_o   = old_i;
    load_o     = '0;
    misalign_o = dm_misaligned(size_i, lsb_i);
    unique case (size_i)
      SZ_BYTE: begin
        merged_o = (old_i & ~(32'h0000_00ff << byte_sh)) | ({24'h0, wdata_i[7:0]} << byte_sh);
        load_o   = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        merged_o = (old_i & ~(32'h0000_ffff << half_sh)) | ({16'h0, wdata_i[15:0]} << half_sh);
        load_o   = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        merged_o = wdata_i;
        load_o   = old_i;
      end
      default: begin
        merged_o = old_i;
        load_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: clear-after-reset sequencer, sub-word stores/loads and
// a fixed-latency response path with at most one request outstanding.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 1,
  parameter bit          TRACE   = 1'b1
) (
  input logic      clk,
  input logic      reset,
  dm_ctrl_if.slave bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  // Bit of the latency marker that is set in the last BUSY cycle.
  localparam int unsigned LastIdx = (LATENCY > 1) ? LATENCY - 2 : 0;

  logic [31:0] mem_q [Depth];

  dm_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     clr_idx_q, clr_idx_d;
  logic                  init_done_q, init_done_d;
  logic [DM_LAT_MAX-1:0] lat_sr_q, lat_sr_d;
  logic [31:0]           res_rdata_q, res_rdata_d;
  logic                  res_err_q, res_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic              accept;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       load_val;
  logic [31:0]       result;
  logic              misalign;
  logic              out_of_range;
  logic              req_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign accept       = bus.req_valid && (state_q == StIdle);
  assign widx         = bus.req_addr[ADDR_W+1:2];
  assign old_word     = mem_q[widx];
  assign out_of_range = |(bus.req_addr >> (ADDR_W + 2));
  assign req_err      = out_of_range || misalign || (bus.req_size == SZ_ILL);
  assign result       = (bus.req_we || req_err) ? 32'h0 : load_val;

  dm_byte_lane u_byte_lane (
    .old_i      (old_word),
    .wdata_i    (bus.req_wdata),
    .size_i     (bus.req_size),
    .lsb_i      (bus.req_addr[1:0]),
    .unsigned_i (bus.req_unsigned),
    .merged_o   (merged),
    .load_o     (load_val),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    lat_sr_d    = lat_sr_q;
    res_rdata_d = res_rdata_q;
    res_err_d   = res_err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_waddr   = clr_idx_q;
    mem_wdata   = '0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (&clr_idx_q) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIdle: begin
        if (accept) begin
          // Storage commits at acceptance so a following load always sees the store.
          mem_we    = bus.req_we && !req_err;
          mem_waddr = widx;
          mem_wdata = merged;
          if (LATENCY <= 1) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = result;
            rsp_err_d   = req_err;
          end else begin
            res_rdata_d = result;
            res_err_d   = req_err;
            lat_sr_d    = {{(DM_LAT_MAX-1){1'b0}}, 1'b1};
            state_d     = StBusy;
          end
        end
      end
      StBusy: begin
        lat_sr_d = lat_sr_q << 1;
        if (lat_sr_q[LastIdx]) begin
          lat_sr_d    = '0;
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = res_rdata_q;
          rsp_err_d   = res_err_q;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StClear;
      clr_idx_q   <= '0;
      init_done_q <= 1'b0;
      lat_sr_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
      lat_sr_q    <= lat_sr_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // No reset on the array: the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (TRACE && reset && (state_q == StIdle) && mem_we) begin
      $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged);
    end
  end
`endif

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench: dut_a (ADDR_W=4, LATENCY=1) and dut_b (ADDR_W=10, LATENCY=3).
module tb_dm_ctrl;
  import dm_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  dm_ctrl_if bus_a ();
  dm_ctrl_if bus_b ();

  dm_ctrl #(.ADDR_W(4), .LATENCY(1), .TRACE(1'b1)) u_dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  dm_ctrl #(.ADDR_W(10), .LATENCY(3), .TRACE(1'b0)) u_dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (bus_a.rsp_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check("a_rdata", bus_a.rsp_rdata, e.rdata);
        check("a_err", 32'(bus_a.rsp_err), 32'(e.err));
        check("a_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bus_b.rsp_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        check("b_rdata", bus_b.rsp_rdata, e.rdata);
        check("b_err", 32'(bus_b.rsp_err), 32'(e.err));
        check("b_latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input bit sel, input bit v, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc);
    if (sel) begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_size = size;
      bus_b.req_unsigned = uns; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
      bus_b.req_pc = pc;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_size = size;
      bus_a.req_unsigned = uns; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
      bus_a.req_pc = pc;
    end
  endtask

  // Drives one request, holds it until accepted and queues the expected response.
  task automatic req(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                     input bit e_err, input logic [31:0] e_rdata, output int acc_cyc);
    exp_t e;
    bit   rdy;
    int   n;
    @(negedge clk);
    drive(sel, 1'b1, we, size, uns, addr, wdata, pc);
    n   = 0;
    rdy = sel ? bus_b.req_ready : bus_a.req_ready;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
      rdy = sel ? bus_b.req_ready : bus_a.req_ready;
    end
    if (!rdy) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
      acc_cyc = -1;
      return;
    end
    e.err   = e_err;
    e.rdata = e_rdata;
    e.due   = cyc + (sel ? 3 : 1);
    if (sel) q_b.push_back(e);
    else q_a.push_back(e);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input bit sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_init_b();
    int n;
    n = 0;
    while (bus_b.init_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_init_done", 32'(bus_b.init_done), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : main
    int t0, t1, t2, tx;
    bit seen;
    reset_a = 1'b0;
    reset_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus_a.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'h0);
    check("rst_init_done", 32'(bus_a.init_done), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    reset_b = 1'b1;

    // 16-word clear on dut_a
    repeat (15) @(posedge clk);
    #1;
    check("clr_ready_low", 32'(bus_a.req_ready), 32'd0);
    check("clr_init_low", 32'(bus_a.init_done), 32'd0);
    @(posedge clk);
    #1;
    check("clr_ready_high", 32'(bus_a.req_ready), 32'd1);
    check("clr_init_high", 32'(bus_a.init_done), 32'd1);

    for (int i = 0; i < 16; i++) req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'(i * 4), 32'h0, 32'h0, 1'b0, 32'h0, tx);

    req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h3000, 1'b0, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h3004, 1'b0, 32'hDEAD_BEEF, tx);
    idle(1'b0);
    @(negedge clk);
    check("a_rsp_pulse", 32'(bus_a.rsp_valid), 32'd0);
    check("a_rdata_hold", bus_a.rsp_rdata, 32'hDEAD_BEEF);

    // Sub-word store and extending loads
    req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FF80, 32'h3008, 1'b0, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'h80AD_BEEF, tx);
    req(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 32'hFFFF_FF80, tx);
    req(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h0, 1'b0, 32'h0000_0080, tx);
    req(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 32'hFFFF_80AD, tx);
    req(1'b0, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h0, 1'b0, 32'h0000_80AD, tx);
    req(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFEF, tx);
    req(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 32'h0000_00BE, tx);
    req(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'hFFFF_BEEF, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h0, 1'b0, 32'h80AD_BEEF, tx);

    // Errors leave storage untouched
    req(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h5555, 32'h300C, 1'b1, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 32'h0, tx);
    req(1'b0, 1'b1, SZ_ILL, 1'b0, 32'h10, 32'h1234_5678, 32'h3010, 1'b1, 32'h0, tx);
    req(1'b0, 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 32'h80AD_BEEF, tx);

    // Upper-half store then byte store into lane 1
    req(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234_ABCD, 32'h3014, 1'b0, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 32'hABCD_0000, tx);
    req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h0000_0077, 32'h3018, 1'b0, 32'h0, tx);
    req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 32'hABCD_7700, tx);
    req(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 32'h0, 1'b0, 32'hFFFF_ABCD, tx);
    idle(1'b0);

    // dut_b: LATENCY=3, ADDR_W=10
    wait_init_b();
    req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h4000, 1'b0, 32'h0, tx);
    req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 32'h0, tx);
    req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, t0);
    req(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, 32'h0, 1'b0, 32'h0000_00F0, t1);
    req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, 32'h0, 1'b0, 32'hFFFF_CAFE, t2);
    check("b_accept_gap1", t1 - t0, 32'd3);
    check("b_accept_gap2", t2 - t1, 32'd3);
    idle(1'b1);
    check("b_busy_ready_t1", 32'(bus_b.req_ready), 32'd0);
    @(negedge clk);
    check("b_busy_ready_t2", 32'(bus_b.req_ready), 32'd0);
    @(negedge clk);
    check("b_ready_rsp_cycle", 32'(bus_b.req_ready), 32'd1);

    // Reset during BUSY suppresses the response and re-clears storage
    req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h24, 32'h1111_2222, 32'h4010, 1'b0, 32'h0, tx);
    idle(1'b1);
    repeat (4) @(negedge clk);
    check("b_ready_pre_rst", 32'(bus_b.req_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, 32'h4014);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    reset_b = 1'b0;
    #1;
    check("b_rst_init_low", 32'(bus_b.init_done), 32'd0);
    check("b_rst_ready_low", 32'(bus_b.req_ready), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus_b.rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("b_no_rsp_after_rst", 32'(seen), 32'd0);
    reset_b = 1'b1;
    wait_init_b();
    req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0, 32'h0, tx);
    req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 32'h0, tx);
    idle(1'b1);
    repeat (5) @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
